w_debounce: RTL and testbench
=============================

W_DEBOUNCE -- requirements
Module: w_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples required before the output level changes; legal range 2..65535.
REQ-002 Parameter BOUNCE_W, default 8, width of the aborted-transition diagnostic counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 w_raw  input  1  unsynchronized level from a switch or button.
REQ-006 w  output  1  debounced level; drives the w input of the downstream sequence detector.
REQ-007 w_rise  output  1  one-cycle pulse when w goes 0->1.
REQ-008 w_fall  output  1  one-cycle pulse when w goes 1->0.
REQ-009 bounce_cnt  output  BOUNCE_W  saturating count of aborted transitions.

Function
REQ-010 w_raw SHALL pass through a two-flop synchronizer (s1, s2); only s2 (w_sync) feeds the control logic.
REQ-011 The FSM SHALL have the states LO, WAIT_HI, HI and WAIT_LO.
REQ-012 LO: w_sync=1 -> WAIT_HI with the counter cleared to 0; otherwise stay in LO.
REQ-013 WAIT_HI: w_sync=0 -> LO, bounce_cnt increments; w_sync=1 with count<DEBOUNCE_CYCLES-1 -> count increments; w_sync=1 with count=DEBOUNCE_CYCLES-1 -> HI.
REQ-014 HI and WAIT_LO SHALL mirror LO and WAIT_HI with the polarity inverted: WAIT_LO aborts back to HI and increments bounce_cnt.
REQ-015 w SHALL be registered and equal 1 exactly when the state is HI or WAIT_LO.
REQ-016 Latency: if edge k is the first edge to sample w_raw=1 and w_raw stays 1, w SHALL become 1 at edge k+DEBOUNCE_CYCLES+2; the falling direction is symmetric.
REQ-017 w_rise SHALL be registered and high for exactly the one cycle that begins when w goes 0->1; w_fall is the same for 1->0.
REQ-018 w_rise and w_fall SHALL never be high in the same cycle.
REQ-019 bounce_cnt SHALL saturate at all-ones and never wrap.
REQ-020 A w_sync change in the same cycle that the count reaches its terminal value SHALL count as an abort; no transition occurs.
REQ-021 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-022 Unreachable state encodings SHALL return to LO on the next edge with w=0.

Reset
REQ-023 Asserting rst SHALL immediately force s1=0, s2=0, state=LO, count=0, w=0, w_rise=0, w_fall=0 and bounce_cnt=0, regardless of clk.
REQ-024 rst asserted mid-WAIT_HI SHALL discard the partial count; after release, a full DEBOUNCE_CYCLES window is required again.
REQ-025 The first edge after reset release SHALL sample w_raw normally; no pulse SHALL be generated by the release itself.

Structure
REQ-026 The state encodings SHALL live in the shared package w_debounce_pkg as 2-bit constants: LO=00, WAIT_HI=01, HI=10, WAIT_LO=11.
REQ-027 The synchronizer SHALL be a separate sub-module, sync2, with its own asynchronous active-high reset, reusable for other raw inputs.
REQ-028 The FSM, counter and pulse logic SHALL stay in w_debounce: a next-state combinational block plus a single registered block.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-029 Clean step: w_raw 0->1 first sampled at edge 10 and held -> w=1 from edge 16; w_rise high for one cycle only; bounce_cnt=0.
REQ-030 Bounce: w_raw 1 for 2 cycles, 0 for 1 cycle, then 1 held -> w rises 6 edges after the final rising sample; bounce_cnt=1; no early w_rise.
REQ-031 Release: from w=1, w_raw 1->0 held -> w=0 exactly 6 edges later; w_fall pulses once.
REQ-032 Saturation: BOUNCE_W=2, five aborted rises -> bounce_cnt stays at 3.
REQ-033 Reset mid-wait: rst pulsed asynchronously between edges while in WAIT_HI -> all outputs 0 immediately; after release with w_raw still 1, w rises DEBOUNCE_CYCLES+2 edges later.
REQ-034 Chained: w_debounce feeding the sequence detector, w_raw held 1 -> detector z asserts 1 cycle after w rises and drops to 0 after 1 cycle in that state, since the detector then moves on.

Source files
------------

// File: rtl/w_debounce_pkg.sv
// Shared types for the w_debounce slice.
// Two-bit FSM state encodings used by the debouncer.
package w_debounce_pkg;

  typedef enum logic [1:0] {
    LO      = 2'b00,
    WAIT_HI = 2'b01,
    HI      = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous level.
// Reusable for any raw input crossing into clk.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/w_debounce.sv
// Switch debouncer: sync2 front end, 4-state FSM,
// registered level, edge pulses and abort counter.
module w_debounce
  import w_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BOUNCE_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_raw,
  output logic                w,
  output logic                w_rise,
  output logic                w_fall,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic                w_sync;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_abort;
  logic                w_lvl_nxt;
  logic                r_w;
  logic                r_rise;
  logic                r_fall;
  logic [BOUNCE_W-1:0] r_bounce;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (w_raw),
    .o_q (w_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort     = 1'b0;
    case (r_state)
      LO: begin
        if (w_sync) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!w_sync) begin
          w_state_nxt = LO;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == TERM) begin
          w_state_nxt = HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HI: begin
        if (!w_sync) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (w_sync) begin
          w_state_nxt = HI;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == TERM) begin
          w_state_nxt = LO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level follows the next state so w lands on the same edge as the FSM.
  assign w_lvl_nxt = (w_state_nxt == HI) ||
                     (w_state_nxt == WAIT_LO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= LO;
      r_cnt    <= '0;
      r_w      <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_bounce <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_w     <= w_lvl_nxt;
      r_rise  <= w_lvl_nxt & ~r_w;
      r_fall  <= ~w_lvl_nxt & r_w;
      if (w_abort && (r_bounce != '1))
        r_bounce <= r_bounce + 1'b1;
    end
  end

  assign w          = r_w;
  assign w_rise     = r_rise;
  assign w_fall     = r_fall;
  assign bounce_cnt = r_bounce;

endmodule

// File: tb/tb_w_debounce.sv
// Scoreboard bench for w_debounce against a
// run-length model of the debounce rules.
module tb_w_debounce;

  localparam int D  = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_raw = 1'b0;
  logic          w;
  logic          w_rise;
  logic          w_fall;
  logic [BW-1:0] bounce_cnt;

  typedef struct packed {
    logic          w;
    logic          rise;
    logic          fall;
    logic [BW-1:0] bc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   pass_n = 0;
  int   tot_n  = 0;

  bit   m_s1, m_s2, m_lvl, m_rise, m_fall;
  int   m_run, m_bc, lat;

  w_debounce #(
    .DEBOUNCE_CYCLES (D),
    .BOUNCE_W        (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_raw      (w_raw),
    .w          (w),
    .w_rise     (w_rise),
    .w_fall     (w_fall),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0;
    m_run = 0; m_bc = 0;
    m_rise = 0; m_fall = 0;
  endtask

  // Level flips after D+1 consecutive synced samples
  // differing from it; a shorter run that ends is an abort.
  task automatic model_edge(bit raw);
    bit smp;
    smp = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    m_rise = 0;
    m_fall = 0;
    if (smp != m_lvl) begin
      m_run++;
      if (m_run == D + 1) begin
        m_lvl = smp;
        m_run = 0;
        if (smp) m_rise = 1;
        else m_fall = 1;
      end
    end else begin
      if (m_run > 0 && m_bc < (1 << BW) - 1) m_bc++;
      m_run = 0;
    end
  endtask

  task automatic cyc(bit v);
    w_raw = v;
    @(posedge clk);
    model_edge(v);
    q.push_back('{m_lvl, m_rise, m_fall, BW'(m_bc)});
    #1;
  endtask

  task automatic settle(string nm, bit v);
    cyc(v);
    lat = 0;
    while (w !== v && lat < 40) begin
      cyc(v);
      lat++;
    end
    chk(nm, lat, D + 2);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("w", w, e.w);
      chk("w_rise", w_rise, e.rise);
      chk("w_fall", w_fall, e.fall);
      chk("bounce_cnt", bounce_cnt, e.bc);
      chk("rise_fall_excl", w_rise & w_fall, 0);
    end
  end

  task automatic chk_zero(string nm);
    chk({nm, "_w"}, w, 0);
    chk({nm, "_rise"}, w_rise, 0);
    chk({nm, "_fall"}, w_fall, 0);
    chk({nm, "_bc"}, bounce_cnt, 0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    #10 rst = 1'b0;

    repeat (4) cyc(0);
    settle("rise_lat", 1'b1);
    repeat (3) cyc(1);
    chk("clean_bc", bounce_cnt, 0);
    settle("fall_lat", 1'b0);
    repeat (3) cyc(0);

    cyc(1); cyc(1); cyc(0);
    settle("bounce_lat", 1'b1);
    chk("bounce_bc", bounce_cnt, 1);
    repeat (D + 4) cyc(0);

    repeat (5) begin
      cyc(1); cyc(0); cyc(0);
    end
    repeat (3) cyc(0);
    chk("sat_bc", bounce_cnt, 3);

    repeat (3) cyc(1);
    #1 rst = 1'b1;
    #1 chk_zero("midwait_rst");
    q.delete();
    model_reset();
    #1 rst = 1'b0;
    settle("post_rst_lat", 1'b1);

    repeat (60) begin
      bit v;
      int n;
      v = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 8);
      repeat (n) cyc(v);
    end
    repeat (3) cyc(w_raw);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
